// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the LED matrix row-scan controller:
// scan states, matrix geometry and the column rotate helper.
package matrix_scan_ctrl_pkg;

  localparam int ROW_COUNT = 16;
  localparam int COL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Upper half of the doubled word shifted left is the left rotation.
  function automatic logic [COL_WIDTH-1:0] rotl(input logic [COL_WIDTH-1:0] w,
                                                input logic [3:0]           s);
    logic [2*COL_WIDTH-1:0] dbl;
    dbl = {w, w} << s;
    return dbl[2*COL_WIDTH-1 -: COL_WIDTH];
  endfunction

endpackage

// File: rtl/matrix_scan_ctrl_slot_timer.sv
// Row-slot prescaler: counts 0..TICK_DIV-1 while running and flags the
// last blanking cycle and the last cycle of the slot.
module matrix_scan_ctrl_slot_timer
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 2500,
  parameter int BLANK_CYC = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == SLOT_LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign blank_done_o = (cnt_q == BLANK_LAST);
  assign slot_done_o  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-scan sequencer for a 16x16 LED matrix: blank/show row slots, pattern
// selection with frame-aligned advance, and frame-stepped column scrolling.
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV       = 2500,
  parameter int BLANK_CYC      = 50,
  parameter int NUM_PAT        = 5,
  parameter int FRAMES_PER_PAT = 60,
  parameter int SCROLL_FRAMES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 auto_mode,
  input  logic                 btn_next,
  input  logic                 scroll_en,
  input  logic [COL_WIDTH-1:0] col_in,
  output logic [3:0]           row_bin,
  output logic [2:0]           pat_sel,
  output logic [ROW_COUNT-1:0] row_out,
  output logic [COL_WIDTH-1:0] col_out,
  output logic                 frame_tick
);

  localparam int HW = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
  localparam int SW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST   = HW'(FRAMES_PER_PAT - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_FRAMES - 1);
  localparam logic [2:0]    PAT_LAST    = 3'(NUM_PAT - 1);
  localparam logic [3:0]    ROW_LAST    = 4'(ROW_COUNT - 1);

  scan_state_e          state_q, state_d;
  logic [3:0]           row_bin_q, row_bin_d;
  logic [2:0]           pat_sel_q, pat_sel_d;
  logic [ROW_COUNT-1:0] row_out_q, row_out_d;
  logic [COL_WIDTH-1:0] col_out_q, col_out_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [SW-1:0]        scroll_cnt_q, scroll_cnt_d;
  logic [3:0]           scroll_off_q, scroll_off_d;
  logic                 pend_q, pend_d;
  logic                 frame_end, adv_req;
  logic                 tmr_clr, blank_done, slot_done;

  assign tmr_clr = (state_q == IDLE) || !en;

  matrix_scan_ctrl_slot_timer #(
    .TICK_DIV  (TICK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (tmr_clr),
    .blank_done_o (blank_done),
    .slot_done_o  (slot_done)
  );

  always_comb begin
    state_d      = state_q;
    row_bin_d    = row_bin_q;
    pat_sel_d    = pat_sel_q;
    row_out_d    = row_out_q;
    col_out_d    = col_out_q;
    frame_tick_d = 1'b0;
    hold_d       = hold_q;
    scroll_cnt_d = scroll_cnt_q;
    scroll_off_d = scroll_off_q;
    pend_d       = pend_q | btn_next;
    frame_end    = 1'b0;
    adv_req      = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      row_bin_d = '0;
      row_out_d = '0;
      col_out_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = BLANK;
          row_bin_d = '0;
          row_out_d = '0;
          col_out_d = '0;
        end
        BLANK: begin
          row_out_d = '0;
          // Column word and row enable are loaded on the same edge.
          if (blank_done) begin
            state_d   = SHOW;
            col_out_d = rotl(col_in, scroll_off_q);
            row_out_d = ROW_COUNT'(1) << row_bin_q;
          end
        end
        SHOW: begin
          if (slot_done) begin
            state_d   = BLANK;
            row_bin_d = row_bin_q + 4'd1;
            row_out_d = '0;
            col_out_d = '0;
            frame_end = (row_bin_q == ROW_LAST);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Pattern and scroll only move between frames so a frame never tears.
    if (frame_end) begin
      frame_tick_d = 1'b1;
      adv_req      = pend_q | btn_next | (auto_mode && (hold_q == HOLD_LAST));
      if (adv_req) begin
        pat_sel_d    = (pat_sel_q == PAT_LAST) ? 3'd0 : pat_sel_q + 3'd1;
        pend_d       = 1'b0;
        hold_d       = '0;
        scroll_off_d = '0;
        scroll_cnt_d = '0;
      end else begin
        hold_d = auto_mode ? hold_q + HW'(1) : '0;
        if (scroll_en) begin
          if (scroll_cnt_q == SCROLL_LAST) begin
            scroll_cnt_d = '0;
            scroll_off_d = scroll_off_q + 4'd1;
          end else begin
            scroll_cnt_d = scroll_cnt_q + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      row_bin_q    <= '0;
      pat_sel_q    <= '0;
      row_out_q    <= '0;
      col_out_q    <= '0;
      frame_tick_q <= 1'b0;
      hold_q       <= '0;
      scroll_cnt_q <= '0;
      scroll_off_q <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_bin_q    <= row_bin_d;
      pat_sel_q    <= pat_sel_d;
      row_out_q    <= row_out_d;
      col_out_q    <= col_out_d;
      frame_tick_q <= frame_tick_d;
      hold_q       <= hold_d;
      scroll_cnt_q <= scroll_cnt_d;
      scroll_off_q <= scroll_off_d;
      pend_q       <= pend_d;
    end
  end

  assign row_bin    = row_bin_q;
  assign pat_sel    = pat_sel_q;
  assign row_out    = row_out_q;
  assign col_out    = col_out_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/matrix_scan_ctrl.md
Name: matrix_scan_ctrl

Overview:
Row-scan sequencer for the 16x16 LED dot matrix. It drives the 4-bit row index into the pattern ROM bank, selects which pattern ROM is shown, and latches each returned 16-bit column word. It then drives one-hot row enables with a blanking gap between rows to stop ghosting. It sits between the board clock and the LED matrix pins. The pattern ROMs are combinational, with one ROM per shape.

Parameters:
TICK_DIV, 2500, clk cycles per row slot (blank plus show); must be greater than BLANK_CYC.
BLANK_CYC, 50, clk cycles per row with all rows off, at the start of each slot.
NUM_PAT, 5, number of pattern ROMs; pat_sel counts 0..NUM_PAT-1.
FRAMES_PER_PAT, 60, full frames each pattern is held in auto mode.
SCROLL_FRAMES, 4, frames between 1-column scroll steps.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  scan enable; 0 blanks the display
auto_mode  in  1  1 = advance pattern every FRAMES_PER_PAT frames
btn_next  in  1  single-cycle pulse (already debounced) requesting the next pattern
scroll_en  in  1  1 = rotate columns left over time
col_in  in  16  column word from the selected pattern ROM, valid in the same cycle as row_bin
row_bin  out  4  row index to the pattern ROMs
pat_sel  out  3  pattern ROM mux select
row_out  out  16  one-hot active-high row drive
col_out  out  16  column drive for the currently lit row
frame_tick  out  1  one-cycle pulse after row 15 completes

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; row_bin=0, pat_sel=0, row_out=0, col_out=0, frame_tick=0. Slot, frame, hold and scroll counters all 0. Pending-advance flag cleared.
- FSM states:
  - IDLE: row_out=0, col_out=0. When en=1, go to BLANK with row_bin=0.
  - BLANK: row_out=0. Count BLANK_CYC cycles. On the last cycle, latch col_out <= rotl(col_in, scroll_off), then go to SHOW.
  - SHOW: row_out = 1<<row_bin. Stay TICK_DIV-BLANK_CYC cycles, then go to BLANK with row_bin+1.
- Row wrap: 15 -> 0 wraps row_bin, pulses frame_tick for 1 cycle, and performs all frame-boundary updates.
- Latency: col_out updates 1 cycle after the final BLANK cycle sample, which is the same edge row_out goes non-zero. The row and column never mismatch for any cycle.
- Pattern advance (frame boundaries only, to avoid tearing):
  - btn_next sets the pending flag at any time.
  - In auto_mode, the hold counter reaching FRAMES_PER_PAT-1 also requests an advance.
  - At a frame boundary, if either request is active, pat_sel <= (pat_sel==NUM_PAT-1) ? 0 : pat_sel+1. Then clear the pending flag and the hold counter.
  - A button request and an auto request at the same boundary produce exactly one advance.
  - Multiple btn_next pulses within one frame produce one advance.
- Scroll: scroll_off is 4 bits. At a frame boundary, if scroll_en=1, the scroll counter counts to SCROLL_FRAMES-1 and then scroll_off increments mod 16. scroll_en=0 holds scroll_off.
- Pattern change resets scroll_off to 0.
- en drops mid-frame: go to IDLE on the next edge. row_out, col_out and row_bin are zeroed. The slot counter clears. pat_sel, the pending flag and scroll_off are kept.
- rst mid-operation: all state returns to reset values on that edge, regardless of en.
- Counter widths: sized by $clog2 of each parameter. No counter may exceed its terminal value.

Decomposition:
- Shared package or header: the FSM state encodings (IDLE, BLANK, SHOW), ROW_COUNT=16 and COL_WIDTH=16.
- One sub-module: slot_timer. A prescaler counting to TICK_DIV that emits blank_done and slot_done strobes. The FSM, pattern logic and scroll logic stay in the top level.

Test Plan:
Parameters for all scenarios: TICK_DIV=8, BLANK_CYC=2, NUM_PAT=5, FRAMES_PER_PAT=2, SCROLL_FRAMES=1.
1. Reset then en=1, col_in modelled by pattern ROM 0 -> each slot gives 2 cycles of row_out=0 then 6 cycles of row_out=1<<r with col_out=ROM0[r]. frame_tick pulses every 128 cycles.
2. auto_mode=1 for 10 frames -> pat_sel sequence 0,0,1,1,2,2,3,3,4,4 and then wraps to 0. Each change lands only on a frame_tick edge.
3. btn_next pulsed 3 times at row 5, auto_mode=0 -> single advance at the next frame boundary. btn_next together with an auto expiry -> +1 only.
4. scroll_en=1, ROM word 16'h0FF0 -> col_out equals 16'h1FE0 on the next frame and 16'h3FC0 on the frame after. A pattern change resets the shift to 0.
5. en=0 during SHOW of row 9 -> next cycle row_out=0 and col_out=0. Re-enable -> scan restarts at row_bin=0 in BLANK with pat_sel unchanged.
6. rst asserted mid-SHOW with en=1 -> all outputs 0 on the next edge. The scan restarts from row 0 with pat_sel=0.
